// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares the single-ported unified RAM between the instruction-fetch port
//   (icache / IF stage) and the data port (dcache / MEM stage). The data port
//   has priority. iwait/dwait drive the pipeline hazard logic (hit = !wait).
//   Each grant ends with one IDLE cycle before the next grant is made.
//
// Configuration macro:
//   ARB_STARVE_GUARD_EN - when defined, a 3-bit saturating counter limits how
//   many consecutive data-port grants may complete while a fetch is pending.
//   When the counter reaches STARVE_MAX with iREN high in IDLE, the fetch is
//   granted ahead of the data port. When the macro is undefined, data-port
//   priority is strict and the fetch port can starve.
//
// Parameters:
//   STARVE_MAX - consecutive dport completions tolerated while iREN pends
//                (used only with ARB_STARVE_GUARD_EN)
//
// Ports:
//   CLK        in   rising-edge clock
//   nRST       in   asynchronous active-low reset
//   iREN       in   instruction read request
//   iaddr      in   [31:0] instruction word address
//   iwait      out  1 = fetch not complete this cycle
//   iload      out  [31:0] fetched instruction, valid when iwait==0
//   dREN       in   data read request
//   dWEN       in   data write request (with dREN also high: treated as write)
//   daddr      in   [31:0] data address
//   dstore     in   [31:0] write data
//   dwait      out  1 = data access not complete this cycle
//   dload      out  [31:0] read data, valid when dwait==0 (0 for writes)
//   ramREN     out  RAM read enable
//   ramWEN     out  RAM write enable
//   ramaddr    out  [31:0] RAM address
//   ramstore   out  [31:0] RAM write data
//   ramload    in   [31:0] RAM read data
//   ramstate   in   [1:0] RAM status: FREE=0 BUSY=1 ACCESS=2 ERROR=3
//   arb_state  out  [1:0] current arbiter state (IDLE=0 IFETCH=1 DACCESS=2),
//                   exported for debug and checkers
//
// Handshake:
//   A requester raises its REN/WEN and holds address/data stable until its
//   wait output goes low for one cycle; that cycle is the completion and the
//   load data is valid only then. Dropping the request before completion
//   withdraws it: RAM enables fall in the same cycle and no completion is
//   reported. A port not currently served always sees wait=1 and load=0.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic [1:0]  arb_state
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IFETCH  = 2'd1,
    DACCESS = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic d_req;
  logic ram_ok;
  logic i_done;
  logic d_done;
  logic force_ifetch;

  assign d_req  = dREN | dWEN;
  assign ram_ok = (ramstate == RAM_ACCESS);

  assign arb_state = state;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [2:0] STARVE_LIMIT = 3'(STARVE_MAX);

  logic [2:0] starve_cnt;

  // Counts data-port completions that happened while a fetch was waiting.
  // Any fetch completion, or the fetch port going quiet in IDLE, resets it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt <= 3'd0;
    end else if (i_done) begin
      starve_cnt <= 3'd0;
    end else if ((state == IDLE) && !iREN) begin
      starve_cnt <= 3'd0;
    end else if (d_done && iREN && (starve_cnt != 3'd7)) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  assign force_ifetch = iREN && (starve_cnt >= STARVE_LIMIT);
`else
  assign force_ifetch = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and RAM-side outputs. The served port's completion is flagged
  // by i_done/d_done; the wait outputs are simply their inverses.
  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = 32'd0;
    ramstore   = 32'd0;
    iload      = 32'd0;
    dload      = 32'd0;
    i_done     = 1'b0;
    d_done     = 1'b0;

    case (state)
      IDLE: begin
        if (force_ifetch) begin
          next_state = IFETCH;
        end else if (d_req) begin
          next_state = DACCESS;
        end else if (iREN) begin
          next_state = IFETCH;
        end
      end

      IFETCH: begin
        ramaddr = iaddr;
        if (!iREN) begin
          // Fetch withdrawn (flush): enables stay low, leave without completing.
          next_state = IDLE;
        end else begin
          ramREN = 1'b1;
          if (ram_ok) begin
            i_done     = 1'b1;
            iload      = ramload;
            next_state = IDLE;
          end
        end
      end

      DACCESS: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!d_req) begin
          next_state = IDLE;
        end else if (ram_ok) begin
          d_done     = 1'b1;
          dload      = dWEN ? 32'd0 : ramload;
          next_state = IDLE;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign iwait = ~i_done;
  assign dwait = ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam logic [1:0] R_FREE   = 2'd0;
  localparam logic [1:0] R_BUSY   = 2'd1;
  localparam logic [1:0] R_ACCESS = 2'd2;
  localparam logic [1:0] R_ERROR  = 2'd3;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int STARVE_MAX = 4;

  // ---------------------------------------------------------------- signals
  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic [1:0]  arb_state;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .arb_state(arb_state)
  );

  // ------------------------------------------------------- clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ check task
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------ behavioural model
  // owner: who holds the RAM this cycle (0 = nobody, 1 = fetch port,
  // 2 = data port). starve: dport completions seen while a fetch waited.
  int owner  = 0;
  int starve = 0;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      owner  = 0;
      starve = 0;
    end else begin
      case (owner)
        0: begin
          if (!iREN) starve = 0;
          if (GUARD && iREN && starve >= STARVE_MAX) owner = 1;
          else if (dREN || dWEN)                     owner = 2;
          else if (iREN)                             owner = 1;
        end
        1: begin
          if (!iREN) owner = 0;
          else if (ramstate == R_ACCESS) begin
            owner  = 0;
            starve = 0;
          end
        end
        default: begin
          if (!(dREN || dWEN)) owner = 0;
          else if (ramstate == R_ACCESS) begin
            owner = 0;
            if (iREN && starve < 7) starve = starve + 1;
          end
        end
      endcase
    end
  end

  // Compare process: every cycle, all outputs against the model's view.
  always @(negedge CLK) begin
    logic        e_iwait, e_dwait, e_ren, e_wen;
    logic [31:0] e_iload, e_dload, e_addr, e_store;
    bit          i_on, d_on;
    i_on    = (owner == 1) && iREN;
    d_on    = (owner == 2) && (dREN || dWEN);
    e_iwait = !(i_on && ramstate == R_ACCESS);
    e_dwait = !(d_on && ramstate == R_ACCESS);
    e_iload = e_iwait ? 32'd0 : ramload;
    e_dload = (e_dwait || dWEN) ? 32'd0 : ramload;
    e_ren   = i_on || (d_on && !dWEN);
    e_wen   = d_on && dWEN;
    e_addr  = (owner == 1) ? iaddr : (owner == 2) ? daddr : 32'd0;
    e_store = (owner == 2) ? dstore : 32'd0;
    chk("mdl_iwait",    {31'd0, iwait},    {31'd0, e_iwait});
    chk("mdl_dwait",    {31'd0, dwait},    {31'd0, e_dwait});
    chk("mdl_iload",    iload,             e_iload);
    chk("mdl_dload",    dload,             e_dload);
    chk("mdl_ramREN",   {31'd0, ramREN},   {31'd0, e_ren});
    chk("mdl_ramWEN",   {31'd0, ramWEN},   {31'd0, e_wen});
    chk("mdl_ramaddr",  ramaddr,           e_addr);
    chk("mdl_ramstore", ramstore,          e_store);
  end

  // ---------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    iREN     = 1'b0;
    iaddr    = 32'd0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = 32'd0;
    dstore   = 32'd0;
    ramload  = 32'd0;
    ramstate = R_FREE;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
    tick();
  endtask

  // ------------------------------------------------------ directed stimulus
  initial begin
    int i_cnt;
    int d_cnt;

    idle_inputs();
    nRST = 1'b1;
    #2;

    // Reset with both requests high
    nRST  = 1'b0;
    iREN  = 1'b1;
    dREN  = 1'b1;
    #1;
    chk("rst_iwait",  {31'd0, iwait},  32'd1);
    chk("rst_dwait",  {31'd0, dwait},  32'd1);
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("rst_iload",  iload,           32'd0);
    tick();
    chk("rst_hold_ramREN", {31'd0, ramREN}, 32'd0);
    do_reset();

    // Fetch: BUSY twice then ACCESS
    iREN     = 1'b1;
    iaddr    = 32'h40;
    ramstate = R_BUSY;
    @(negedge CLK);
    chk("fetch_idle_ramREN", {31'd0, ramREN}, 32'd0);
    tick();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        ramstate = R_ACCESS;
        ramload  = 32'h8C010004;
      end
      @(negedge CLK);
      chk("fetch_ramREN",  {31'd0, ramREN}, 32'd1);
      chk("fetch_ramaddr", ramaddr,         32'h40);
      chk("fetch_iwait",   {31'd0, iwait},  (c == 2) ? 32'd0 : 32'd1);
      chk("fetch_iload",   iload,           (c == 2) ? 32'h8C010004 : 32'd0);
      tick();
    end
    iREN = 1'b0;
    @(negedge CLK);
    chk("fetch_after_state", {30'd0, arb_state}, 32'd0);
    chk("fetch_after_ramREN", {31'd0, ramREN}, 32'd0);
    tick();

    // Conflict: data write wins, then fetch is granted
    iREN     = 1'b1;
    iaddr    = 32'h44;
    dWEN     = 1'b1;
    daddr    = 32'h100;
    dstore   = 32'hDEADBEEF;
    ramstate = R_BUSY;
    tick();
    @(negedge CLK);
    chk("conf_ramWEN",   {31'd0, ramWEN}, 32'd1);
    chk("conf_ramREN",   {31'd0, ramREN}, 32'd0);
    chk("conf_ramstore", ramstore,        32'hDEADBEEF);
    chk("conf_ramaddr",  ramaddr,         32'h100);
    chk("conf_iwait",    {31'd0, iwait},  32'd1);
    tick();
    ramstate = R_ACCESS;
    ramload  = 32'h12345678;
    @(negedge CLK);
    chk("conf_dwait", {31'd0, dwait}, 32'd0);
    chk("conf_dload_write", dload, 32'd0);
    chk("conf_iwait_during_d", {31'd0, iwait}, 32'd1);
    tick();
    dWEN = 1'b0;
    @(negedge CLK);
    chk("conf_gap_iwait", {31'd0, iwait}, 32'd1);
    tick();
    ramload = 32'hCAFE0001;
    @(negedge CLK);
    chk("conf_fetch_ramaddr", ramaddr, 32'h44);
    chk("conf_fetch_iwait", {31'd0, iwait}, 32'd0);
    chk("conf_fetch_iload", iload, 32'hCAFE0001);
    tick();
    iREN = 1'b0;
    tick();

    // Flush: fetch withdrawn while RAM busy
    iREN     = 1'b1;
    iaddr    = 32'h80;
    ramstate = R_BUSY;
    tick();
    @(negedge CLK);
    chk("flush_ramREN_before", {31'd0, ramREN}, 32'd1);
    tick();
    iREN     = 1'b0;
    ramstate = R_ACCESS;
    @(negedge CLK);
    chk("flush_ramREN_drop", {31'd0, ramREN}, 32'd0);
    chk("flush_iwait", {31'd0, iwait}, 32'd1);
    tick();
    @(negedge CLK);
    chk("flush_state_idle", {30'd0, arb_state}, 32'd0);
    tick();

    // Error retry on a data read
    dREN     = 1'b1;
    daddr    = 32'h200;
    ramstate = R_ERROR;
    tick();
    @(negedge CLK);
    chk("err_dwait",   {31'd0, dwait},  32'd1);
    chk("err_ramREN",  {31'd0, ramREN}, 32'd1);
    chk("err_ramaddr", ramaddr,         32'h200);
    tick();
    ramstate = R_ACCESS;
    ramload  = 32'h5;
    @(negedge CLK);
    chk("err_dwait_done", {31'd0, dwait}, 32'd0);
    chk("err_dload",      dload,          32'h5);
    tick();
    dREN = 1'b0;
    tick();

    // Read+write together counts as write
    dREN     = 1'b1;
    dWEN     = 1'b1;
    daddr    = 32'h300;
    dstore   = 32'h0000ABCD;
    ramstate = R_ACCESS;
    ramload  = 32'h77;
    tick();
    @(negedge CLK);
    chk("rw_ramWEN", {31'd0, ramWEN}, 32'd1);
    chk("rw_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rw_dload",  dload,           32'd0);
    tick();
    dREN = 1'b0;
    dWEN = 1'b0;
    tick();

    // Reset asserted mid-access
    dREN     = 1'b1;
    daddr    = 32'h400;
    ramstate = R_BUSY;
    tick();
    @(negedge CLK);
    chk("midrst_ramREN_before", {31'd0, ramREN}, 32'd1);
    #2;
    nRST     = 1'b0;
    ramstate = R_ACCESS;
    #1;
    chk("midrst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("midrst_dwait",  {31'd0, dwait},  32'd1);
    do_reset();

    // Starvation pattern over 20 cycles with RAM always ready
    iREN     = 1'b1;
    iaddr    = 32'h500;
    dREN     = 1'b1;
    daddr    = 32'h600;
    ramstate = R_ACCESS;
    ramload  = 32'h9;
    i_cnt    = 0;
    d_cnt    = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (!iwait) i_cnt++;
      if (!dwait) d_cnt++;
      tick();
    end
    chk("starve_i_completions", i_cnt, GUARD ? 32'd2 : 32'd0);
    chk("starve_d_completions", d_cnt, GUARD ? 32'd8 : 32'd10);
    idle_inputs();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
